alu_scheduler: RTL and testbench

ALU_SCHEDULER -- requirements
Module: alu_scheduler

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu.sv | 26 ++
 rtl/alu_scheduler.sv | 122 ++++++++++++
 tb/tb_alu_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and scheduler state type for the ALU scheduler slice.
package alu_pkg;

  localparam logic [3:0] OP_NOT = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_DEC = 4'd4;
  localparam logic [3:0] OP_ADD = 4'd5;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_INC = 4'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU; unused control codes produce zero, arithmetic wraps.
module alu
  import alu_pkg::*;
(
  input  logic [3:0]  ctrl_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  always_comb begin
    y_o = '0;
    case (ctrl_i)
      OP_NOT:  y_o = ~a_i;
      OP_AND:  y_o = a_i & b_i;
      OP_XOR:  y_o = a_i ^ b_i;
      OP_OR:   y_o = a_i | b_i;
      OP_DEC:  y_o = a_i - 32'd1;
      OP_ADD:  y_o = a_i + b_i;
      OP_SUB:  y_o = a_i - b_i;
      OP_INC:  y_o = a_i + 32'd1;
      default: y_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_scheduler.sv
// Two-requester round-robin front end that runs an iterated ALU operation
// (cnt+1 passes, result fed back as A) and returns one response per command.
module alu_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [CNT_W-1:0] req0_cnt,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [CNT_W-1:0] req1_cnt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [31:0]      rsp_data,
  output logic             busy
);

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      b_q, b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             grant1;
  logic             hs;
  logic [31:0]      alu_y;

  // Tie goes to whichever requester was not served last.
  assign grant1 = req1_valid & (~req0_valid | ~last_q);

  always_comb begin
    req0_ready = (state_q == IDLE) & req0_valid & ~grant1 & ~rst;
    req1_ready = (state_q == IDLE) & req1_valid &  grant1 & ~rst;
    hs         = req0_ready | req1_ready;
  end

  alu u_alu (
    .ctrl_i (op_q),
    .a_i    (acc_q),
    .b_i    (b_q),
    .y_o    (alu_y)
  );

  // acc_q is loaded with the operand A at accept time, so the ALU A input is
  // always acc_q: first EXEC cycle sees a, later cycles see the prior result.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          op_d    = grant1 ? req1_op  : req0_op;
          acc_d   = grant1 ? req1_a   : req0_a;
          b_d     = grant1 ? req1_b   : req0_b;
          cnt_d   = grant1 ? req1_cnt : req0_cnt;
          id_d    = grant1;
          last_d  = grant1;
          state_d = EXEC;
        end
      end
      EXEC: begin
        acc_d = alu_y;
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    busy      = (state_q != IDLE);
    rsp_valid = (state_q == DONE);
    rsp_data  = rsp_valid ? acc_q : '0;
    rsp_id    = rsp_valid & id_q;
  end

endmodule

// File: tb/tb_alu_scheduler.sv
// Scoreboard bench for alu_scheduler: handshakes push model results, a monitor
// pops and compares responses, readies, busy and response latency.
module tb_alu_scheduler;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]       req0_op, req1_op;
  logic [31:0]      req0_a, req0_b, req1_a, req1_b;
  logic [CNT_W-1:0] req0_cnt, req1_cnt;
  logic             rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0]      rsp_data;

  alu_scheduler #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_cnt   (req0_cnt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_cnt   (req1_cnt),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
    case (op)
      4'd0:    return ~x;
      4'd1:    return x & y;
      4'd2:    return x ^ y;
      4'd3:    return x | y;
      4'd4:    return x - 32'd1;
      4'd5:    return x + y;
      4'd6:    return x - y;
      4'd7:    return x + 32'd1;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input int cnt);
    logic [31:0] x;
    x = a;
    for (int i = 0; i <= cnt; i++) x = alu_ref(op, x, b);
    return x;
  endfunction

  typedef struct {
    bit          id;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  bit   mon_en     = 1'b0;
  bit   inflight   = 1'b0;
  bit   last       = 1'b1;
  bit   prev_valid = 1'b0;

  always @(negedge clk) begin : monitor
    bit   g, er0, er1;
    exp_t e;
    if (mon_en) begin
      g   = (req0_valid && req1_valid) ? !last : req1_valid;
      er0 = !inflight && !rst && req0_valid && !g;
      er1 = !inflight && !rst && req1_valid && g;
      chk("ready_pair", {req1_ready, req0_ready}, {er1, er0});
      chk("busy", busy, inflight);

      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          chk("rsp_data", rsp_data, sb[0].data);
          chk("rsp_id", rsp_id, sb[0].id);
          if (!prev_valid) chk("rsp_latency", cyc, sb[0].due);
          if (rsp_ready) begin
            void'(sb.pop_front());
            inflight = 1'b0;
          end
        end
      end else if (sb.size() > 0 && cyc >= sb[0].due) begin
        chk("rsp_missing", rsp_valid, 1'b1);
      end
      prev_valid = rsp_valid && !rsp_ready;

      if (er0 || er1) begin
        e.id   = g;
        e.data = g ? model(req1_op, req1_a, req1_b, int'(req1_cnt))
                   : model(req0_op, req0_a, req0_b, int'(req0_cnt));
        e.due  = cyc + 2 + (g ? int'(req1_cnt) : int'(req0_cnt));
        sb.push_back(e);
        inflight = 1'b1;
        last     = g;
        grant_log.push_back(int'(g));
      end

      if (rst) begin
        sb.delete();
        inflight   = 1'b0;
        last       = 1'b1;
        prev_valid = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 200 && (inflight || sb.size() > 0); i++) @(posedge clk);
    if (inflight || sb.size() > 0) chk("idle_timeout", inflight, 1'b0);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit id, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int cnt, output int t);
    @(posedge clk);
    #1;
    if (id) begin
      req1_op = op; req1_a = a; req1_b = b; req1_cnt = CNT_W'(cnt); req1_valid = 1'b1;
    end else begin
      req0_op = op; req0_a = a; req0_b = b; req0_cnt = CNT_W'(cnt); req0_valid = 1'b1;
    end
    t = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) chk("issue_timeout", id ? req1_ready : req0_ready, 1'b1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic run_directed(input bit id, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input int cnt, input logic [31:0] exp_data);
    int t;
    issue(id, op, a, b, cnt, t);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
    end
    chk("dir_valid", rsp_valid, 1'b1);
    chk("dir_data", rsp_data, exp_data);
    chk("dir_id", rsp_id, id);
    chk("dir_latency", cyc - t, 2 + cnt);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t;
    int  tie_exp [4] = '{0, 1, 0, 1};
    bit  seen;

    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 4'd7; req0_a = 32'h10; req0_b = 32'h0; req0_cnt = '0;
    req1_valid = 1'b1; req1_op = 4'd5; req1_a = 32'd100; req1_b = 32'd1; req1_cnt = CNT_W'(1);

    @(posedge clk);
    #1 mon_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, 1'b0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_req0_ready", req0_ready, 1'b0);
    chk("rst_req1_ready", req1_ready, 1'b0);

    // Both requesters held valid straight out of reset.
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 200 && grant_log.size() < 4; i++) @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("tie_grant_count", grant_log.size() >= 4, 1'b1);
    for (int i = 0; i < 4; i++) chk("tie_grant", (i < grant_log.size()) ? grant_log[i] : -1, tie_exp[i]);
    wait_idle();

    run_directed(1'b0, 4'd5, 32'd3,          32'd4, 0, 32'd7);
    run_directed(1'b1, 4'd7, 32'hFFFF_FFFE,  32'd0, 3, 32'h0000_0002);
    run_directed(1'b0, 4'd5, 32'd1,          32'd2, 2, 32'd7);
    run_directed(1'b1, 4'd9, 32'h1234_5678,  32'hFF, 1, 32'h0);
    run_directed(1'b0, 4'd6, 32'd0,          32'd1, 0, 32'hFFFF_FFFF);
    run_directed(1'b1, 4'd4, 32'd0,          32'd9, 0, 32'hFFFF_FFFF);
    run_directed(1'b0, 4'd0, 32'h0F0F_0000,  32'd0, 1, 32'h0F0F_0000);

    // Backpressure in DONE with the other requester knocking.
    rsp_ready = 1'b0;
    issue(1'b0, 4'd5, 32'd10, 32'd20, 2, t);
    for (int i = 0; i < 60 && !rsp_valid; i++) @(negedge clk);
    @(posedge clk);
    #1 req1_valid = 1'b1; req1_op = 4'd1; req1_cnt = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1'b1);
      chk("bp_data", rsp_data, 32'd70);
      chk("bp_id", rsp_id, 1'b0);
      chk("bp_busy", busy, 1'b1);
      chk("bp_req1_ready", req1_ready, 1'b0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1; req1_valid = 1'b0;
    wait_idle();

    // Reset during the fifth EXEC cycle of a long command.
    issue(1'b1, 4'd7, 32'd0, 32'd0, 15, t);
    while (cyc < t + 5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", rsp_valid, 1'b0);
    chk("mid_rst_data", rsp_data, 32'h0);
    chk("mid_rst_id", rsp_id, 1'b0);
    chk("mid_rst_ready", {req1_ready, req0_ready}, 2'b00);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    chk("mid_rst_no_rsp", seen, 1'b0);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      req0_valid = ($urandom_range(0, 2) == 0);
      req1_valid = ($urandom_range(0, 2) == 0);
      req0_op    = 4'($urandom_range(0, 15));
      req1_op    = 4'($urandom_range(0, 15));
      req0_a     = $urandom;
      req1_a     = $urandom;
      req0_b     = $urandom;
      req1_b     = $urandom;
      req0_cnt   = CNT_W'($urandom_range(0, 15));
      req1_cnt   = CNT_W'($urandom_range(0, 3));
      rsp_ready  = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b1;
    wait_idle();
    chk("final_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
